// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_if
// Purpose  : Byte-stream input handshake and instruction/data memory write
//            port of the program loader, bundled as one interface.
// Signals  : in_data[7:0], in_valid  - byte stream from the host side
//            in_ready                - loader accepts a byte this cycle
//            mem_we                  - one-cycle memory write strobe
//            mem_addr[ADDR_WIDTH-1:0], mem_data[31:0] - write address / word
// Modports : master - byte source and memory (drives the stream, sees writes)
//            slave  - the loader itself
// Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_data
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_data
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Receives a program as a serial byte stream (16-bit big-endian
//            word count, 4*N big-endian data bytes, XOR checksum byte),
//            writes each 32-bit word to memory and holds the CPU until the
//            load completes with a matching checksum.
// Ports    : clk       - single clock, rising edge
//            rst_n     - synchronous active-low reset
//            start     - one-cycle load request (IDLE/DONE/ERROR only)
//            bus       - prog_loader_if.slave: byte stream + memory write port
//            cpu_hold  - CPU must not fetch/retire while high
//            done      - load finished, checksum matched
//            error     - load aborted (length over limit / bad checksum)
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start,
  prog_loader_if.slave       bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_LEN_HI     = 3'd1;
  localparam logic [2:0] c_LEN_LO     = 3'd2;
  localparam logic [2:0] c_DATA       = 3'd3;
  localparam logic [2:0] c_CSUM       = 3'd4;
  localparam logic [2:0] c_WRITE_LAST = 3'd5;
  localparam logic [2:0] c_DONE       = 3'd6;
  localparam logic [2:0] c_ERROR      = 3'd7;

  localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

  logic [2:0]            r_state;
  logic [15:0]           r_len;
  logic [15:0]           r_word_cnt;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_word;
  logic [7:0]            r_csum;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_data;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [15:0]           w_len;
  logic                  w_last_word;

  assign w_in_ready  = (r_state == c_LEN_HI) || (r_state == c_LEN_LO) ||
                       (r_state == c_DATA)   || (r_state == c_CSUM);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_len       = {r_len[15:8], bus.in_data};
  assign w_last_word = (r_word_cnt + 16'd1) == r_len;

  assign bus.in_ready = w_in_ready;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;

  // A start request in DONE raises hold in the request cycle itself, so the
  // CPU never runs while the next load is being set up.
  assign cpu_hold = (r_state != c_DONE) || start;
  assign done     = (r_state == c_DONE);
  assign error    = (r_state == c_ERROR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_len      <= 16'd0;
      r_word_cnt <= 16'd0;
      r_byte_idx <= 2'd0;
      r_word     <= 24'd0;
      r_csum     <= 8'd0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= 32'd0;
    end else begin
      // Strobe is one cycle wide; address/data registers simply hold.
      r_mem_we <= 1'b0;
      case (r_state)
        c_IDLE, c_DONE, c_ERROR: begin
          if (start) begin
            r_state    <= c_LEN_HI;
            r_len      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'd0;
          end
        end
        c_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= bus.in_data;
            r_state     <= c_LEN_LO;
          end
        end
        c_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= bus.in_data;
            if ({1'b0, w_len} > c_MAX_WORDS) begin
              r_state <= c_ERROR;
            end else if (w_len == 16'd0) begin
              r_state <= c_CSUM;
            end else begin
              r_state <= c_DATA;
            end
          end
        end
        c_DATA: begin
          if (w_accept) begin
            r_csum     <= r_csum ^ bus.in_data;
            r_word     <= {r_word[15:0], bus.in_data};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Write is registered: it fires next cycle while the stream
              // keeps flowing into the next word (or the checksum byte).
              r_mem_we   <= 1'b1;
              r_mem_data <= {r_word, bus.in_data};
              r_mem_addr <= r_word_cnt[ADDR_WIDTH-1:0];
              r_word_cnt <= r_word_cnt + 16'd1;
              if (w_last_word) begin
                r_state <= c_CSUM;
              end
            end
          end
        end
        c_CSUM: begin
          if (w_accept) begin
            r_state <= (bus.in_data == r_csum) ? c_DONE : c_ERROR;
          end
        end
        c_WRITE_LAST: begin
          // The final write is already held in the output registers when
          // CSUM is entered, so leaving CSUM can never collide with it and
          // this state is not entered in normal operation; if ever reached
          // it returns to the checksum phase without touching the write.
          r_state <= c_CSUM;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader. Loads are generated as byte
//            lists; a reference model derives the expected memory writes and
//            final status from the byte list alone. Expected writes go into a
//            scoreboard queue that a negedge monitor drains on every mem_we.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
  localparam int AW   = 10;
  localparam int MAXW = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold;
  logic done;
  logic error;

  prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

  prog_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [7:0]    bq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  logic [AW-1:0] mon_a;
  logic [31:0]   mon_d;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        chk("spurious_we", 64'(bus.mem_we), 64'd0);
      end else begin
        mon_a = exp_addr_q.pop_front();
        mon_d = exp_data_q.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(mon_a));
        chk("wr_data", 64'(bus.mem_data), 64'(mon_d));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_mem_we"},   64'(bus.mem_we),   64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_data"}, 64'(bus.mem_data), 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold),     64'd1);
    chk({tag, "_done"},     64'(done),         64'd0);
    chk({tag, "_error"},    64'(error),        64'd0);
  endtask

  // Offer one byte after 'gap' idle cycles; returns whether it was taken
  // and how many cycles it waited for in_ready.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start,
                           output bit ok, output int stalls);
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    start        = with_start;
    ok           = 1'b0;
    stalls       = 0;
    while (!ok && stalls < 50) begin
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (!ok) stalls++;
    end
    bus.in_valid = 1'b0;
  endtask

  // gapmode: 0 = valid every cycle, 1 = alternate valid 1,0, 2 = random gaps
  task automatic run_load(input int gapmode, input bit rnd_start, output bit exp_done);
    int   n, nbytes, gap, st, stall_total;
    bit   over, match, ok, timeout;
    logic [7:0] csum;

    // Reference model: derived purely from the byte list.
    n      = int'({bq[0], bq[1]});
    over   = n > MAXW;
    nbytes = over ? 2 : 2 + 4 * n + 1;
    match  = 1'b0;
    if (!over) begin
      csum = 8'd0;
      for (int i = 0; i < 4 * n; i++) csum ^= bq[2 + i];
      match = (bq[2 + 4 * n] == csum);
      for (int w = 0; w < n; w++) begin
        exp_addr_q.push_back(AW'(w));
        exp_data_q.push_back({bq[2+4*w], bq[3+4*w], bq[4+4*w], bq[5+4*w]});
      end
    end
    exp_done = !over && match;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_hold",  64'(cpu_hold),     64'd1);
    chk("start_ready", 64'(bus.in_ready), 64'd1);
    chk("start_done",  64'(done),         64'd0);

    stall_total = 0;
    timeout     = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      gap = (gapmode == 0) ? 0 : (gapmode == 1) ? ((i > 0) ? 1 : 0) : int'($urandom_range(0, 3));
      send_byte(bq[i], gap, rnd_start && (i == 3), ok, st);
      stall_total += st;
      if (!ok) begin
        timeout = 1'b1;
        break;
      end
    end
    chk("byte_timeout", 64'(timeout), 64'd0);
    if (gapmode == 0) chk("no_stall", 64'(stall_total), 64'd0);

    // Status right after the final byte (or the 2nd byte when over length).
    chk("done",         64'(done),         64'(exp_done));
    chk("error",        64'(error),        64'(!exp_done));
    chk("cpu_hold",     64'(cpu_hold),     64'(!exp_done));
    chk("in_ready_end", 64'(bus.in_ready), 64'd0);

    // Stray bytes after the load must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("writes_left", 64'(exp_addr_q.size()), 64'd0);
    chk("done_hold",   64'(done),  64'(exp_done));
    chk("error_hold",  64'(error), 64'(!exp_done));
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic build_random(input int n, input bit bad_csum);
    logic [7:0] c, b;
    bq.delete();
    bq.push_back(8'(n >> 8));
    bq.push_back(8'(n));
    if (n <= MAXW) begin
      c = 8'd0;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        c ^= b;
        bq.push_back(b);
      end
      bq.push_back(bad_csum ? (c ^ 8'(1 << $urandom_range(0, 7))) : c);
    end
  endtask

  initial begin
    bit ed;
    bit ok;
    int st;
    int n;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset, with in_valid and start driven to show reset has priority.
    rst_n = 1'b0;
    start = 1'b1;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    check_reset_vals("reset");

    // in_valid while idle: not accepted.
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("idle_ready", 64'(bus.in_ready), 64'd0);
    chk("idle_hold",  64'(cpu_hold),     64'd1);

    // Two-word load; checksum byte is the XOR of the eight data bytes (0x26).
    bq = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
    run_load(0, 1'b0, ed);
    chk("normal_ok", 64'(done), 64'd1);

    // Same stream, valid toggling 1,0,1,0.
    run_load(1, 1'b0, ed);

    // Bad checksum: one write then error.
    bq = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    run_load(0, 1'b0, ed);
    chk("badcsum_err", 64'(error), 64'd1);

    // Over length: 0x0401 = 1025 words.
    bq = '{8'h04, 8'h01};
    run_load(0, 1'b0, ed);

    // Zero length, then a restart from DONE.
    bq = '{8'h00, 8'h00, 8'h00};
    run_load(0, 1'b0, ed);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_done",  64'(done),         64'd0);
    chk("restart_hold",  64'(cpu_hold),     64'd1);
    chk("restart_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset after the 3rd data byte: partial word never written.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE};
    for (int i = 0; i < 5; i++) send_byte(bq[i], 0, 1'b0, ok, st);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midreset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Randomized loads.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(MAXW + 1, 65535));
      else n = int'($urandom_range(0, 6));
      build_random(n, $urandom_range(0, 3) == 0);
      run_load(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ed);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
